// File: rtl/pspi_slave_rx_if.sv
// PSPI slave receive bus: serial pins from the master plus received-byte outputs.
// err_count exists only when PSPI_ERR_COUNT_EN is defined.
interface pspi_slave_rx_if;
  logic       sclk;
  logic       select;
  logic       mosi;
  logic       miso;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
`ifdef PSPI_ERR_COUNT_EN
  logic [7:0] err_count;

  modport master (
    output sclk, select, mosi,
    input  miso, data_out, data_valid,
    input  parity_err, frame_err, err_count
  );

  modport slave (
    input  sclk, select, mosi,
    output miso, data_out, data_valid,
    output parity_err, frame_err, err_count
  );
`else
  modport master (
    output sclk, select, mosi,
    input  miso, data_out, data_valid,
    input  parity_err, frame_err
  );

  modport slave (
    input  sclk, select, mosi,
    output miso, data_out, data_valid,
    output parity_err, frame_err
  );
`endif
endinterface

// File: rtl/pspi_slave_rx.sv
// PSPI slave receiver: 8 data bits + parity per frame, retransmit request on miso.
// Optional saturating error counter enabled by defining PSPI_ERR_COUNT_EN.
module pspi_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input logic           clk_in,
  input logic           rst,
  pspi_slave_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP,
    CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sel_prev_q, sel_prev_d;
  logic [2:0]             flush_q, flush_d;
  logic                   armed_q, armed_d;

  logic sclk_s, sel_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic sel_rise, sel_fall;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] shift_q, shift_d;
  logic       perr_q, perr_d;
  logic       miso_q, miso_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_pls_q, perr_pls_d;
  logic       ferr_q, ferr_d;
`ifdef PSPI_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
`endif

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sel_s  = sel_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign sel_rise  = sel_s & ~sel_prev_q;
  // A select low seen straight after reset belongs to an interrupted
  // frame; only accept a fall once select was seen high post-flush.
  assign sel_fall  = armed_q & ~sel_s & sel_prev_q;

  // Synchronizer shift, edge history and post-reset arming.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], bus.select};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_prev_d = sclk_s;
    sel_prev_d  = sel_s;
    flush_d     = flush_q;
    if (flush_q != 3'(SYNC_STAGES)) begin
      flush_d = flush_q + 3'd1;
    end
    armed_d = armed_q |
              ((flush_q == 3'(SYNC_STAGES)) & sel_s);
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      sel_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      sel_prev_q  <= 1'b1;
      flush_q     <= 3'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sel_sync_q  <= sel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      sel_prev_q  <= sel_prev_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  // Frame FSM next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    miso_d     = miso_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_pls_d = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (sel_fall) begin
          state_d = SHIFT;
          cnt_d   = 4'd0;
          shift_d = 8'h00;
          perr_d  = 1'b0;
        end
      end
      SHIFT: begin
        miso_d = 1'b0;
        if (sel_rise) begin
          state_d = CHECK;
        end else if (sclk_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], mosi_s};
          end else begin
            perr_d  = (^{shift_q, mosi_s}) ^ PARITY_ODD;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (sel_rise) begin
          state_d = CHECK;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            cnt_d = cnt_inc;
          end
          if (sclk_fall) begin
            miso_d = perr_q;
          end
        end
      end
      CHECK: begin
        miso_d = 1'b0;
        if (cnt_q != 4'd10) begin
          ferr_d = 1'b1;
        end else if (perr_q) begin
          perr_pls_d = 1'b1;
        end else begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
        if (sel_fall) begin
          state_d = SHIFT;
          cnt_d   = 4'd0;
          shift_d = 8'h00;
          perr_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

`ifdef PSPI_ERR_COUNT_EN
  // Saturating count of rejected frames.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((perr_pls_d | ferr_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end
`endif

  // Frame FSM state and outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      perr_q     <= 1'b0;
      miso_q     <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      perr_pls_q <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef PSPI_ERR_COUNT_EN
      err_cnt_q  <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      miso_q     <= miso_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_pls_q <= perr_pls_d;
      ferr_q     <= ferr_d;
`ifdef PSPI_ERR_COUNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign bus.miso       = miso_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_pls_q;
  assign bus.frame_err  = ferr_q;
`ifdef PSPI_ERR_COUNT_EN
  assign bus.err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_pspi_slave_rx.sv
// Scoreboard bench for pspi_slave_rx: frames are queued with their expected
// result at select rise; a monitor pops one entry per output pulse.
module tb_pspi_slave_rx;

  localparam int S    = 2;
  localparam bit PODD = 1'b0;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  pspi_slave_rx_if bus();

  pspi_slave_rx #(
    .SYNC_STAGES(S),
    .PARITY_ODD (PODD)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    int         ecnt;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  logic [7:0] last_good = 8'h00;
  int         ecnt_model = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // kind: 0 = accepted, 1 = parity reject, 2 = bit-count reject
  always @(negedge clk_in) begin : mon
    int   n;
    int   kind_act;
    exp_t e;
    if (!rst) begin
      n = int'(bus.data_valid) + int'(bus.parity_err) +
          int'(bus.frame_err);
      if (n != 0) begin
        if (n > 1) chk("single_pulse", n, 1);
        kind_act = bus.data_valid ? 0 : (bus.parity_err ? 1 : 2);
        if (q.size() == 0) begin
          chk("pulse_without_frame", kind_act + 10, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", kind_act, e.kind);
          chk("data_out", bus.data_out, e.data);
          chk("latency_cycle", cyc, e.cyc);
`ifdef PSPI_ERR_COUNT_EN
          chk("err_count", bus.err_count, e.ecnt);
`endif
        end
      end
    end
  end

  function automatic bit parity_bad(logic [7:0] d, logic p);
    return ($countones({d, p}) % 2) != int'(PODD);
  endfunction

  function automatic logic good_par(logic [7:0] d);
    return logic'(($countones(d) % 2) != int'(PODD));
  endfunction

  task automatic push_result(logic [7:0] d, logic p, int n);
    int k;
    if (n != 10)                k = 2;
    else if (parity_bad(d, p))  k = 1;
    else                        k = 0;
    if (k == 0) last_good = d;
    else if (ecnt_model < 255) ecnt_model++;
    q.push_back('{k, last_good, cyc + S + 2, ecnt_model});
  endtask

  task automatic send(logic [7:0] d, logic p, int n, int gap);
    bit err;
    err = parity_bad(d, p);
    bus.select = 1'b0;
    tick(6);
    for (int i = 0; i < n; i++) begin
      bus.mosi = (i < 8) ? d[7-i] : ((i == 8) ? p : 1'b0);
      if (i == 8) chk("miso_before_resp", bus.miso, 0);
      tick(4);
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
    end
    tick(S + 4);
    chk("miso_hold", bus.miso, (n >= 9) ? 32'(err) : 0);
    bus.select = 1'b1;
    bus.mosi   = 1'b0;
    push_result(d, p, n);
    tick(gap);
    if (gap >= S + 3) chk("miso_idle", bus.miso, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    int         n;
    int         gap;
    int         r;

    bus.sclk   = 1'b0;
    bus.select = 1'b1;
    bus.mosi   = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_data_valid", bus.data_valid, 0);
    chk("reset_parity_err", bus.parity_err, 0);
    chk("reset_frame_err", bus.frame_err, 0);
    chk("reset_miso", bus.miso, 0);
    rst = 1'b0;
    tick(10);

    send(8'hA5, 1'b0, 10, 8);
    send(8'hA5, 1'b1, 10, 8);
    send(8'h3C, 1'b1, 10, 2);
    send(8'h3C, 1'b0, 10, 8);
    send(8'h6E, 1'b0, 6, 8);
    send(8'h55, 1'b1, 10, 1);
    send(8'h55, 1'b0, 10, 8);
    send(8'h0F, 1'b0, 16, 8);
    send(8'hF0, 1'b1, 9, 8);

    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
      tick(4);
    end
    tick(10);
    chk("queue_before_reset", q.size(), 0);

    bus.select = 1'b0;
    tick(6);
    d = 8'h81;
    for (int i = 0; i < 10; i++) begin
      bus.mosi = (i < 8) ? d[7-i] : 1'b0;
      tick(4);
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
      if (i == 4) begin
        rst = 1'b1;
        tick(2);
        chk("midreset_data_out", bus.data_out, 0);
        chk("midreset_miso", bus.miso, 0);
        chk("midreset_pulses",
            {bus.data_valid, bus.parity_err, bus.frame_err}, 0);
        last_good  = 8'h00;
        ecnt_model = 0;
        rst = 1'b0;
      end
    end
    tick(S + 4);
    bus.select = 1'b1;
    bus.mosi   = 1'b0;
    tick(12);
    chk("after_interrupted_data_out", bus.data_out, 0);
    send(8'h81, 1'b0, 10, 8);

    send(8'h12, ~good_par(8'h12), 10, 8);
    send(8'h34, ~good_par(8'h34), 10, 8);
    send(8'h56, ~good_par(8'h56), 10, 8);
    send(8'h78, good_par(8'h78), 4, 8);

    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      p = good_par(d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 10;
      r = int'($urandom_range(0, 2));
      gap = (r == 0) ? 1 : ((r == 1) ? 2 : 8);
      send(d, p, n, gap);
    end
    tick(10);

`ifdef PSPI_ERR_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 1'b0, 1, 3);
    end
    tick(10);
    chk("err_count_saturated", bus.err_count, 255);
`endif

    tick(20);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/pspi_slave_rx.md
PSPI_SLAVE_RX -- requirements
Module: pspi_slave_rx

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth for sclk/select/mosi (legal 2..4).
REQ-002 SHALL have parameter: PARITY_ODD, 0, 0 = even parity over data+parity bit, 1 = odd.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk_in  input  1  system clock (100 MHz); all logic on posedge.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: sclk  input  1  serial clock from PSPI master, idle low.
REQ-007 SHALL have port: select  input  1  active-low frame select from master, idle high.
REQ-008 SHALL have port: mosi  input  1  serial data from master.
REQ-009 SHALL have port: miso  output  1  error response to master (master's error_control); 1 = retransmit.
REQ-010 SHALL have port: data_out  output  8  last accepted byte.
REQ-011 SHALL have port: data_valid  output  1  one-clk_in pulse, data_out updated.
REQ-012 SHALL have port: parity_err  output  1  one-clk_in pulse, frame rejected for parity.
REQ-013 SHALL have port: frame_err  output  1  one-clk_in pulse, frame rejected for bit count.

Function
REQ-014 SHALL pass sclk, select, mosi through SYNC_STAGES flops each; edges detected on synchronized values only.
REQ-015 SHALL implement FSM IDLE, SHIFT, RESP, CHECK; IDLE -> SHIFT on synchronized select falling edge, clearing bit count (4 bits) and shift register.
REQ-016 In SHIFT, each synchronized sclk rising edge SHALL sample mosi and increment bit count; samples 1-8 = data MSB first, sample 9 = parity bit.
REQ-017 On the 9th rising edge SHALL compute parity error per PARITY_ODD and enter RESP.
REQ-018 In RESP, on the next sclk falling edge miso SHALL be driven to the parity error flag and held until select rises; the 10th rising edge is counted, no data sampled.
REQ-019 miso SHALL be 0 in IDLE, SHIFT and CHECK.
REQ-020 On synchronized select rising edge in SHIFT or RESP SHALL enter CHECK for one cycle, then IDLE.
REQ-021 In CHECK with count == 10 and no parity error: data_out <= 8 data bits, data_valid = 1 for one cycle.
REQ-022 In CHECK with count == 10 and parity error: parity_err = 1 for one cycle; data_out unchanged.
REQ-023 In CHECK with count != 10 (short, or more than 10 edges; count saturates at 15): frame_err = 1 for one cycle; data_out unchanged; parity_err not asserted.
REQ-024 sclk edges while select high SHALL be ignored.
REQ-025 A select falling edge in CHECK SHALL be honoured: CHECK completes, then directly SHIFT (back-to-back retransmission).
REQ-026 Latency: data_valid SHALL assert SYNC_STAGES+2 clk_in cycles after select rises at the pin.
REQ-027 Each retransmitted frame SHALL be handled independently; no retry limit in the slave.

Reset
REQ-028 rst SHALL force FSM to IDLE, clear counters, shift register and synchronizers to idle values (sclk 0, select 1, mosi 0).
REQ-029 rst SHALL force miso, data_valid, parity_err, frame_err to 0 and data_out to 8'h00.
REQ-030 After reset mid-frame, block SHALL wait for a fresh select falling edge; remainder of the interrupted frame ignored.

Configuration
REQ-031 With PSPI_ERR_COUNT_EN defined, SHALL add output err_count, 8 bits, incrementing on each parity_err or frame_err pulse, saturating at 255, cleared by rst.
REQ-032 Without PSPI_ERR_COUNT_EN, err_count port and logic SHALL not exist; all other behaviour identical.

Verification
REQ-033 Frame 0xA5, parity bit 0, PARITY_ODD=0, 10 sclk cycles -> miso 0, data_valid pulse, data_out = 8'hA5.
REQ-034 Frame 0xA5, parity bit 1 -> miso 1 from 9th falling edge to select high, parity_err pulse, data_out keeps prior value.
REQ-035 Bad 0x3C frame then good 0x3C retransmission with 2 select-high cycles between -> one parity_err then one data_valid, data_out = 8'h3C.
REQ-036 Select low, 6 sclk cycles, select high -> frame_err pulse, no data_valid, miso 0 throughout.
REQ-037 rst asserted after 5th sclk edge, released, then full 0x81 frame -> outputs zero during rst, then data_valid with data_out = 8'h81.
REQ-038 PSPI_ERR_COUNT_EN defined, 3 bad-parity frames and 1 short frame -> err_count = 4; 300 errors -> err_count = 255.
